// File: rtl/occ_pkg.sv
// Shared types and constants for the cell FIFO reader: FSM state encoding
// and the default bit position of the end-of-packet flag.
package occ_pkg;

    localparam int unsigned EOP_BIT = 15;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO-ordered output buffer; entry 0 is always the oldest word.
// The caller never pushes while full and never pops while empty.
module skid_buf2 #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   occ
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) e0 <= din;
                    else             e1 <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                // Simultaneous push and pop: occupancy unchanged, order kept.
                2'b11: begin
                    if (occ == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head = e0;

endmodule

// File: rtl/cell_fifo_reader.sv
// Pops packet words from a first-word-fall-through FIFO, tags sop/eop, and
// forwards them downstream; pause takes effect only at packet boundaries.
module cell_fifo_reader #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned EOP_BIT = occ_pkg::EOP_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              pause,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              paused,
    output logic [15:0]       pkt_cnt
);

    import occ_pkg::*;

    localparam int unsigned ENTRY_W = DATA_W + 2;

    state_t             state;
    logic               in_pkt;
    logic               permit;
    logic               rd_eop;
    logic               pop;
    logic [1:0]         occ;
    logic [ENTRY_W-1:0] head;

    // Reads stop between packets while pausing; downstream stalls only via occ.
    assign permit     = (state != HOLD) && !(pause && !in_pkt);
    assign fifo_rd_en = rst && !fifo_empty && (occ != 2'd2) && permit;
    assign rd_eop     = fifo_dout[EOP_BIT];
    assign pop        = out_valid && out_ready;

    skid_buf2 #(.W(ENTRY_W)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_rd_en),
        .din  ({fifo_dout, !in_pkt, rd_eop}),
        .pop  (pop),
        .head (head),
        .occ  (occ)
    );

    assign out_data  = head[ENTRY_W-1:2];
    assign out_sop   = head[1];
    assign out_eop   = head[0];
    assign out_valid = (occ != 2'd0);
    assign paused    = (state == HOLD);

    // Pause FSM, packet tracking and delivered-packet counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            in_pkt  <= 1'b0;
            pkt_cnt <= 16'd0;
        end else begin
            if (fifo_rd_en) in_pkt <= !rd_eop;
            if (pop && out_eop) pkt_cnt <= pkt_cnt + 16'd1;
            case (state)
                RUN:     if (pause) state <= in_pkt ? DRAIN : HOLD;
                DRAIN: begin
                    if (!pause)                            state <= RUN;
                    else if ((fifo_rd_en && rd_eop) || !in_pkt) state <= HOLD;
                end
                HOLD:    if (!pause) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule
